// File: rtl/fifo_pkg.sv
// fifo_pkg: shared async-FIFO definitions (pointer width, Gray conversions).
// Used by the write-side wfull block, the read-side empty block and the FIFO top.
// Contents:
//   DEPTH, N, PW  default FIFO depth, address width and pointer width (N+1)
//   bin2gray      binary to Gray, any width up to 32 (caller truncates)
//   gray2bin      Gray to binary, any width up to 32 (input zero-extended)
package fifo_pkg;
   localparam int DEPTH = 8;
   localparam int N = $clog2(DEPTH);
   localparam int PW = N + 1;
   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction
   // Each binary bit is the XOR of all Gray bits at or above it.
   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      for (int i = 0; i < 32; i++) b[i] = ^(g >> i);
      return b;
   endfunction
endpackage

// File: rtl/wfull_if.sv
// wfull_if: write-side handshake bundle between producer/FIFO top and wfull.
// Signals:
//   winc          producer write request
//   wq2_rptr      Gray read pointer from the read domain (asynchronous)
//   waddr, wen    memory write address / enable
//   wptr          registered Gray write pointer toward the read domain
//   wfull, wovf   full flag, overflow pulse
//   walmost_full  only when WFULL_ALMOST_EN is defined
// Modports: master (producer side), slave (wfull block).
interface wfull_if #(parameter int n = fifo_pkg::N);
   logic         winc;
   logic [n:0]   wq2_rptr;
   logic [n-1:0] waddr;
   logic         wen;
   logic [n:0]   wptr;
   logic         wfull;
   logic         wovf;
`ifdef WFULL_ALMOST_EN
   logic         walmost_full;
   modport master(output winc, wq2_rptr, input waddr, wen, wptr, wfull, wovf, walmost_full);
   modport slave(input winc, wq2_rptr, output waddr, wen, wptr, wfull, wovf, walmost_full);
`else
   modport master(output winc, wq2_rptr, input waddr, wen, wptr, wfull, wovf);
   modport slave(input winc, wq2_rptr, output waddr, wen, wptr, wfull, wovf);
`endif
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: generic two-flop synchronizer with async active-low reset.
// Ports:
//   clk    destination clock
//   rst_n  asynchronous active-low reset, clears both stages
//   d      asynchronous input (Gray-coded so at most one bit moves at a time)
//   q      synchronized output (second stage)
module sync_2ff #(parameter int W = 4) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] s0;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {q, s0} <= '0;
      else {q, s0} <= {s0, d};
endmodule

// File: rtl/wfull.sv
// wfull: async-FIFO write pointer, Gray pointer export and full/overflow flags.
// Ports:
//   wclk    write-domain clock
//   wrst_n  asynchronous active-low reset
//   w       wfull_if.slave: winc, wq2_rptr in; waddr, wen, wptr, wfull, wovf
//           (and walmost_full) out
// Optional feature: define WFULL_ALMOST_EN to add walmost_full, asserted when
// the occupancy after this edge is at least depth - afull_thr.
module wfull
   import fifo_pkg::*;
#(
   parameter int depth = 8,
   parameter int n = $clog2(depth),
   parameter int afull_thr = 2
) (
   input logic wclk,
   input logic wrst_n,
   wfull_if.slave w
);
   localparam int pw = n + 1;
   logic [n:0] wbin, wbin_next, wgray_next, s1;
   sync_2ff #(.W(pw)) u_sync (.clk(wclk), .rst_n(wrst_n), .d(w.wq2_rptr), .q(s1));
   assign w.wen = w.winc & ~w.wfull;
   assign w.waddr = wbin[n-1:0];
   assign wbin_next = wbin + {{n{1'b0}}, w.wen};
   assign wgray_next = pw'(bin2gray(32'(wbin_next)));
   // Full when the next write pointer equals the read pointer with its top
   // two Gray bits inverted (same address, opposite wrap).
   always_ff @(posedge wclk or negedge wrst_n)
      if (!wrst_n) begin
         wbin   <= '0;
         w.wptr <= '0;
         w.wfull <= 1'b0;
         w.wovf <= 1'b0;
      end else begin
         wbin   <= wbin_next;
         w.wptr <= wgray_next;
         w.wfull <= wgray_next == {~s1[n:n-1], s1[n-2:0]};
         w.wovf <= w.winc & w.wfull;
      end
`ifdef WFULL_ALMOST_EN
   logic [n:0] rbin_s, used;
   assign rbin_s = pw'(gray2bin(32'(s1)));
   assign used = wbin_next - rbin_s;
   always_ff @(posedge wclk or negedge wrst_n)
      if (!wrst_n) w.walmost_full <= 1'b0;
      else w.walmost_full <= int'(used) >= depth - afull_thr;
`endif
endmodule

// File: tb/tb_wfull.sv
// tb_wfull: self-checking bench for wfull (depth 8) using vector tables and a
// scoreboard queue of expected post-edge results.
module tb_wfull;
   import fifo_pkg::*;
   logic wclk = 1'b0;
   logic wrst_n = 1'b0;
   int checks = 0;
   int errors = 0;
   wfull_if #(.n(3)) w();
   wfull #(.depth(8), .afull_thr(2)) dut (.wclk(wclk), .wrst_n(wrst_n), .w(w.slave));
   always #5 wclk = ~wclk;

   typedef struct {
      logic       winc;
      logic [3:0] rptr;
      logic       wen;
      logic [2:0] waddr;
      logic [3:0] wptr;
      logic       full;
      logic       ovf;
      logic       af;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];

   function automatic vec_t mk(logic winc, logic [3:0] rptr, logic wen, logic [2:0] waddr,
                               logic [3:0] wptr, logic full, logic ovf, logic af);
      vec_t v;
      v.winc = winc; v.rptr = rptr; v.wen = wen; v.waddr = waddr;
      v.wptr = wptr; v.full = full; v.ovf = ovf; v.af = af;
      return v;
   endfunction

   function automatic logic [3:0] g(int k);
      logic [3:0] b;
      b = 4'(k);
      return b ^ (b >> 1);
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive at negedge, check combinational outputs, then check registered
   // outputs 1 time unit after the posedge against the scoreboard.
   task automatic apply(vec_t v);
      vec_t e;
      @(negedge wclk);
      w.winc = v.winc;
      w.wq2_rptr = v.rptr;
      sb.push_back(v);
      #1;
      chk("wen", 32'(w.wen), 32'(v.wen));
      chk("waddr", 32'(w.waddr), 32'(v.waddr));
      @(posedge wclk);
      #1;
      e = sb.pop_front();
      chk("wptr", 32'(w.wptr), 32'(e.wptr));
      chk("wfull", 32'(w.wfull), 32'(e.full));
      chk("wovf", 32'(w.wovf), 32'(e.ovf));
`ifdef WFULL_ALMOST_EN
      chk("walmost_full", 32'(w.walmost_full), 32'(e.af));
`endif
   endtask

   task automatic do_reset();
      @(negedge wclk);
      wrst_n = 1'b0;
      w.winc = 1'b0;
      w.wq2_rptr = '0;
      repeat (2) @(negedge wclk);
      wrst_n = 1'b1;
   endtask

   initial begin
      w.winc = 1'b0;
      w.wq2_rptr = '0;
      #2;
      chk("rst_waddr", 32'(w.waddr), 0);
      chk("rst_wptr", 32'(w.wptr), 0);
      chk("rst_wfull", 32'(w.wfull), 0);
      chk("rst_wovf", 32'(w.wovf), 0);
      do_reset();
      // Idle after reset, then fill 8 entries with the reader stalled at 0.
      tbl.push_back(mk(0, 4'b0000, 0, 3'd0, 4'b0000, 0, 0, 0));
      tbl.push_back(mk(0, 4'b0000, 0, 3'd0, 4'b0000, 0, 0, 0));
      for (int k = 0; k < 8; k++)
         tbl.push_back(mk(1, 4'b0000, 1, 3'(k), g(k + 1), k == 7, 0, k >= 5));
      // Write while full: dropped, one-cycle overflow pulse.
      tbl.push_back(mk(1, 4'b0000, 0, 3'd0, 4'b1100, 1, 1, 1));
      tbl.push_back(mk(0, 4'b0000, 0, 3'd0, 4'b1100, 1, 0, 1));
      // Reader advances one entry: full clears on the third edge.
      tbl.push_back(mk(0, 4'b0001, 0, 3'd0, 4'b1100, 1, 0, 1));
      tbl.push_back(mk(0, 4'b0001, 0, 3'd0, 4'b1100, 1, 0, 1));
      tbl.push_back(mk(0, 4'b0001, 0, 3'd0, 4'b1100, 0, 0, 1));
      tbl.push_back(mk(1, 4'b0001, 1, 3'd0, 4'b1101, 1, 0, 1));
      for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
      // 16 writes with the reader trailing one Gray step per cycle.
      do_reset();
      for (int i = 0; i < 16; i++)
         apply(mk(1, g(i), 1, 3'(i % 8), g((i + 1) % 16), 0, 0, 0));
      chk("wrap_wptr", 32'(w.wptr), 0);
      // Asynchronous reset with 5 entries written, between clock edges.
      do_reset();
      for (int i = 0; i < 5; i++)
         apply(mk(1, 4'b0000, 1, 3'(i), g(i + 1), 0, 0, 0));
      @(negedge wclk);
      w.winc = 1'b0;
      #2;
      chk("pre_arst_waddr", 32'(w.waddr), 5);
      wrst_n = 1'b0;
      #1;
      chk("arst_waddr", 32'(w.waddr), 0);
      chk("arst_wptr", 32'(w.wptr), 0);
      chk("arst_wfull", 32'(w.wfull), 0);
      chk("arst_wovf", 32'(w.wovf), 0);
`ifdef WFULL_ALMOST_EN
      chk("arst_walmost_full", 32'(w.walmost_full), 0);
`endif
      @(negedge wclk);
      wrst_n = 1'b1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
